// File: rtl/pipe_share_pkg.sv
// Shared types and constants for the two-requester pipeline share arbiter.
package pipe_share_pkg;

    localparam int DEF_DATA_W = 32;

    typedef logic src_t;

    localparam src_t SRC_1 = 1'b0;
    localparam src_t SRC_2 = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer to use next.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       ptr,
    input  logic       rot_en,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    // ptr=0 favours req[0], ptr=1 favours req[1]
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
        ptr_nxt = ptr;
        if (rot_en && gnt[0])      ptr_nxt = 1'b1;
        else if (rot_en && gnt[1]) ptr_nxt = 1'b0;
    end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one stall-based output stage between two producers; serialises their flushes.
// Optional grant counters are built when PIPE_SHARE_ARB_STATS_EN is defined.
module pipe_share_arbiter
    import pipe_share_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter bit RR_INIT = 1'b0,
    parameter int STATS_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_flush_1,
    input  logic              in_valid_2,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              in_flush_2,
    output logic              out_stall_1,
    output logic              out_stall_2,
    output logic              pipe_valid,
    output logic [DATA_W-1:0] pipe_data,
    output src_t              pipe_src,
    output logic              pipe_flush,
    output src_t              pipe_flush_src,
    input  logic              pipe_stall
`ifdef PIPE_SHARE_ARB_STATS_EN
   ,input  logic               stats_clr,
    output logic [STATS_W-1:0] grant_cnt_1,
    output logic [STATS_W-1:0] grant_cnt_2
`endif
);

    if (STATS_W < 1) begin : g_stats_w_chk
        $error("pipe_share_arbiter: STATS_W must be at least 1");
    end

    out_state_t state, state_nxt;
    logic       can_load;
    logic [1:0] gnt;
    logic       rr_ptr, rr_ptr_nxt;
    logic [1:0] flush_pend, flush_pend_nxt, flush_req, flush_cand, flush_iss;

    assign can_load = (state == OUT_EMPTY) || !pipe_stall;

    rr_arb2 u_rr (
        .req     ({in_valid_2, in_valid_1}),
        .en      (can_load),
        .ptr     (rr_ptr),
        .rot_en  (can_load),
        .gnt     (gnt),
        .ptr_nxt (rr_ptr_nxt)
    );

    assign out_stall_1 = in_valid_1 && !gnt[0];
    assign out_stall_2 = in_valid_2 && !gnt[1];

    // Output stage FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= OUT_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (can_load) state_nxt = (gnt != 2'b00) ? OUT_FULL : OUT_EMPTY;
    end

    always_comb begin
        pipe_valid = (state == OUT_FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_data <= '0;
            pipe_src  <= SRC_1;
            rr_ptr    <= RR_INIT;
        end else begin
            rr_ptr <= rr_ptr_nxt;
            if (can_load && gnt != 2'b00) begin
                pipe_data <= gnt[1] ? in_data_2 : in_data_1;
                pipe_src  <= gnt[1] ? SRC_2 : SRC_1;
            end
        end
    end

    // Fresh flush requests are eligible in the cycle they arrive, so a lone
    // flush reaches pipe_flush one cycle later, like a data beat.
    assign flush_req  = {in_flush_2, in_flush_1};
    assign flush_cand = flush_pend | flush_req;
    assign flush_iss  = {flush_cand[1] & ~flush_cand[0], flush_cand[0]};

    // A new request that collides with the issue of an older one stays pending
    assign flush_pend_nxt = (flush_cand & ~flush_iss) | (flush_req & flush_pend & flush_iss);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_pend     <= 2'b00;
            pipe_flush     <= 1'b0;
            pipe_flush_src <= SRC_1;
        end else begin
            flush_pend     <= flush_pend_nxt;
            pipe_flush     <= |flush_cand;
            pipe_flush_src <= flush_iss[1] ? SRC_2 : SRC_1;
        end
    end

`ifdef PIPE_SHARE_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_1 <= '0;
            grant_cnt_2 <= '0;
        end else if (stats_clr) begin
            grant_cnt_1 <= '0;
            grant_cnt_2 <= '0;
        end else begin
            if (gnt[0] && grant_cnt_1 != '1) grant_cnt_1 <= grant_cnt_1 + STATS_W'(1);
            if (gnt[1] && grant_cnt_2 != '1) grant_cnt_2 <= grant_cnt_2 + STATS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with a beat scoreboard.
module tb_pipe_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_1, in_flush_1, in_valid_2, in_flush_2;
    logic [31:0] in_data_1, in_data_2;
    logic        out_stall_1, out_stall_2;
    logic        pipe_valid, pipe_src, pipe_flush, pipe_flush_src, pipe_stall;
    logic [31:0] pipe_data;
`ifdef PIPE_SHARE_ARB_STATS_EN
    logic        stats_clr;
    logic [3:0]  grant_cnt_1, grant_cnt_2;
`endif

    int n_pass = 0;
    int n_tot  = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_share_arbiter #(.DATA_W(32), .RR_INIT(1'b0), .STATS_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_1     (in_valid_1),
        .in_data_1      (in_data_1),
        .in_flush_1     (in_flush_1),
        .in_valid_2     (in_valid_2),
        .in_data_2      (in_data_2),
        .in_flush_2     (in_flush_2),
        .out_stall_1    (out_stall_1),
        .out_stall_2    (out_stall_2),
        .pipe_valid     (pipe_valid),
        .pipe_data      (pipe_data),
        .pipe_src       (pipe_src),
        .pipe_flush     (pipe_flush),
        .pipe_flush_src (pipe_flush_src),
        .pipe_stall     (pipe_stall)
`ifdef PIPE_SHARE_ARB_STATS_EN
       ,.stats_clr      (stats_clr),
        .grant_cnt_1    (grant_cnt_1),
        .grant_cnt_2    (grant_cnt_2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle of stimulus; the expected stall pattern also tells which beat is granted.
    task automatic step(input logic v1, input logic [31:0] d1, input logic f1,
                        input logic v2, input logic [31:0] d2, input logic f2,
                        input logic st, input logic es1, input logic es2);
        @(posedge clk);
        #1;
        in_valid_1 = v1; in_data_1 = d1; in_flush_1 = f1;
        in_valid_2 = v2; in_data_2 = d2; in_flush_2 = f2;
        pipe_stall = st;
        @(negedge clk);
        chk("stall_1", {31'b0, out_stall_1}, {31'b0, es1});
        chk("stall_2", {31'b0, out_stall_2}, {31'b0, es2});
        if (v1 && !es1)      sb_q.push_back({1'b0, d1});
        else if (v2 && !es2) sb_q.push_back({1'b1, d2});
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Accepted beats are compared against the scoreboard in order
    always @(negedge clk) begin
        if (reset === 1'b1 && pipe_valid === 1'b1 && pipe_stall === 1'b0) begin
            chk("beat_expected", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("beat_src",  {31'b0, pipe_src}, {31'b0, e[32]});
                chk("beat_data", pipe_data, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b0;
        in_valid_1 = 1'b0; in_data_1 = '0; in_flush_1 = 1'b0;
        in_valid_2 = 1'b0; in_data_2 = '0; in_flush_2 = 1'b0;
        pipe_stall = 1'b0;
`ifdef PIPE_SHARE_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #12;
        chk("rst_valid",     {31'b0, pipe_valid}, 32'd0);
        chk("rst_data",      pipe_data, 32'd0);
        chk("rst_src",       {31'b0, pipe_src}, 32'd0);
        chk("rst_flush",     {31'b0, pipe_flush}, 32'd0);
        chk("rst_flush_src", {31'b0, pipe_flush_src}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Both requesters streaming: strict alternation, requester 1 first
        step(1'b1, 32'h10, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_lat0", {31'b0, pipe_valid}, 32'd0);
        step(1'b1, 32'h12, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_lat1", {31'b0, pipe_valid}, 32'd1);
        step(1'b1, 32'h12, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h14, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0);

        // Lone requester 1 gets back-to-back grants
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h20 + 32'(2 * i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hold 0x30 under downstream stall; pointer must still favour requester 2
        step(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h32, 1'b0, 1'b1, 32'h31, 1'b0, 1'b1, 1'b1, 1'b1);
            chk("t3_hold_data",  pipe_data, 32'h30);
            chk("t3_hold_valid", {31'b0, pipe_valid}, 32'd1);
        end
        step(1'b1, 32'h32, 1'b0, 1'b1, 32'h31, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h32, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous flushes serialise with requester 1 first
        step(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h42, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_flush_a",     {31'b0, pipe_flush}, 32'd1);
        chk("t4_flush_a_src", {31'b0, pipe_flush_src}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h43, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_flush_b",     {31'b0, pipe_flush}, 32'd1);
        chk("t4_flush_b_src", {31'b0, pipe_flush_src}, 32'd1);
        idle();
        chk("t4_flush_done", {31'b0, pipe_flush}, 32'd0);
        idle();

        // Reset while full with requester 2's flush still pending
        step(1'b1, 32'h50, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid_1 = 1'b0; in_flush_1 = 1'b0; in_flush_2 = 1'b0;
        @(negedge clk);
        chk("t5_pre_full", {31'b0, pipe_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, pipe_valid}, 32'd0);
        chk("t5_rst_flush", {31'b0, pipe_flush}, 32'd0);
        chk("t5_rst_data",  pipe_data, 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        idle();
        chk("t5_no_stale_a", {31'b0, pipe_flush}, 32'd0);
        idle();
        chk("t5_no_stale_b", {31'b0, pipe_flush}, 32'd0);
        step(1'b1, 32'h60, 1'b0, 1'b1, 32'h61, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h62, 1'b0, 1'b1, 32'h61, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        idle();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef PIPE_SHARE_ARB_STATS_EN
        // Counter saturation and clear-beats-increment
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'h70 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t6_cnt1_sat", {28'b0, grant_cnt_1}, 32'd15);
        chk("t6_cnt2",     {28'b0, grant_cnt_2}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_1 = 1'b1; in_data_1 = 32'h90; stats_clr = 1'b1;
        sb_q.push_back({1'b0, 32'h90});
        @(posedge clk);
        #1;
        in_valid_1 = 1'b0; stats_clr = 1'b0;
        @(negedge clk);
        chk("t6_clr_wins", {28'b0, grant_cnt_1}, 32'd0);
        idle();
        idle();
        chk("sb_drained_stats", 32'(sb_q.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
